// File: rtl/wallace_mul_arbiter.sv
// rtl/wallace_mul_arbiter.sv - round-robin sequencer sharing one multicycle 32x32 multiplier
// Define MUL_ARB_SIGNED_EN for two's-complement operands (magnitude in, sign fix-up on capture).
module wallace_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    output logic [NREQ-1:0]    resp_valid,
    input  logic [NREQ-1:0]    resp_ready,
    output logic [63:0]        resp_data,
    output logic [31:0]        mul_a,
    output logic [31:0]        mul_b,
    input  logic [63:0]        mul_out
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, owner_q, gnt_idx, owner_next;
    logic [3:0]    cnt_q;
    logic [31:0]   idx;
    logic          gnt_found, accept, cnt_done, resp_done;
    logic [31:0]   sel_a, sel_b, op_a, op_b;
    logic [63:0]   product;

    // Rotating priority search starting at ptr, wrapping at NREQ-1.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = 32'(ptr_q) + 32'(k);
            if (idx >= 32'(NREQ)) idx = idx - 32'(NREQ);
            if (!gnt_found && req_valid[idx[PW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[PW-1:0];
            end
        end
    end

    assign accept     = (state_q == S_IDLE) && gnt_found;
    assign cnt_done   = (state_q == S_WAIT) && (cnt_q == 4'd1);
    assign resp_done  = (state_q == S_RESP) && resp_ready[owner_q];
    assign owner_next = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    assign sel_a      = req_a[32*gnt_idx +: 32];
    assign sel_b      = req_b[32*gnt_idx +: 32];

    always_comb begin
        req_ready = '0;
        if (accept && rst_n) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        resp_valid = '0;
        if (state_q == S_RESP) resp_valid[owner_q] = 1'b1;
    end

`ifdef MUL_ARB_SIGNED_EN
    logic neg_q;

    // 0x80000000 negates to itself, which is exactly its magnitude as unsigned.
    assign op_a    = sel_a[31] ? (~sel_a + 32'd1) : sel_a;
    assign op_b    = sel_b[31] ? (~sel_b + 32'd1) : sel_b;
    assign product = (neg_q && (mul_out != 64'd0)) ? (~mul_out + 64'd1) : mul_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else if (accept) begin
            neg_q <= sel_a[31] ^ sel_b[31];
        end
    end
`else
    assign op_a    = sel_a;
    assign op_b    = sel_b;
    assign product = mul_out;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (gnt_found) state_d = S_WAIT;
            S_WAIT:  if (cnt_q == 4'd1) state_d = S_RESP;
            S_RESP:  if (resp_ready[owner_q]) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // mul_a/mul_b only load on accept, so they hold through WAIT and RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            resp_data <= '0;
        end else begin
            if (accept) begin
                owner_q <= gnt_idx;
                mul_a   <= op_a;
                mul_b   <= op_b;
                cnt_q   <= 4'(LAT);
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (cnt_done) resp_data <= product;
            if (resp_done) ptr_q <= owner_next;
        end
    end
endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// tb/tb_wallace_mul_arbiter.sv - self-checking bench for wallace_mul_arbiter against an arithmetic reference
module tb_wallace_mul_arbiter;
    localparam int NREQ = 4;
    localparam int LAT  = 2;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]    resp_valid;
    logic [NREQ-1:0]    resp_ready;
    logic [63:0]        resp_data;
    logic [31:0]        mul_a;
    logic [31:0]        mul_b;
    logic [63:0]        mul_out;

    int n_checks = 0;
    int n_pass   = 0;

    wallace_mul_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_out    (mul_out)
    );

    // Stand-in for the combinational multiplier instance.
    assign mul_out = {32'd0, mul_a} * {32'd0, mul_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_ARB_SIGNED_EN
        int sa, sb;
        sa = a;
        sb = b;
        return 64'(longint'(sa) * longint'(sb));
`else
        return {32'd0, a} * {32'd0, b};
`endif
    endfunction

    function automatic logic [31:0] ref_mag(input logic [31:0] a);
`ifdef MUL_ARB_SIGNED_EN
        int sa;
        sa = a;
        return (sa < 0) ? 32'(-sa) : a;
`else
        return a;
`endif
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        return NREQ'(1) << i;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic single_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_valid = onehot(i);
        #1;
        chk("single_ready", 64'(req_ready), 64'(onehot(i)));
        tick();
        req_valid = '0;
        chk("single_mul_a", 64'(mul_a), 64'(ref_mag(a)));
        chk("single_mul_b", 64'(mul_b), 64'(ref_mag(b)));
        repeat (LAT - 1) tick();
        chk("single_early_valid", 64'(resp_valid), 64'd0);
        tick();
        chk("single_resp_valid", 64'(resp_valid), 64'(onehot(i)));
        chk("single_resp_data", resp_data, ref_prod(a, b));
        resp_ready = onehot(i);
        tick();
        resp_ready = '0;
        chk("single_resp_done", 64'(resp_valid), 64'd0);
    endtask

    logic [63:0] prod_q[$];
    int          own_q[$];
    int          due_q[$];
    int          g, o, due, n_acc, n_resp, last_acc, exp_idx;
    bit          acc_pending, seen_bad;
    logic [31:0] pa, pb, a1, b1, a3, b3;
    logic [63:0] pp;

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        req_a      = '0;
        req_b      = '0;

        // Reset state, with valids raised to show req_ready is gated by rst_n.
        #1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = $urandom;
            req_b[32*i +: 32] = $urandom;
        end
        req_valid = '1;
        #1;
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        chk("reset_resp_valid", 64'(resp_valid), 64'd0);
        chk("reset_resp_data", resp_data, 64'd0);
        chk("reset_mul_a", 64'(mul_a), 64'd0);
        chk("reset_mul_b", 64'(mul_b), 64'd0);
        do_reset();

        // Directed single-requester operations.
        single_op(2, 32'hFFFF_FFFD, 32'd5);
        single_op(2, 32'h8000_0000, 32'h8000_0000);
        single_op(2, 32'h0000_0000, 32'hFFFF_FFFF);
        for (int k = 0; k < 4; k++) single_op(int'($urandom_range(0, NREQ - 1)), $urandom, $urandom);

        // All requesters valid continuously: strict rotation, one accept per LAT+2 cycles.
        do_reset();
        resp_ready = '1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32] = $urandom;
            req_b[32*i +: 32] = $urandom;
        end
        req_valid   = '1;
        n_acc       = 0;
        n_resp      = 0;
        last_acc    = 0;
        exp_idx     = 0;
        acc_pending = 1'b0;
        for (int cyc = 0; cyc < 100 && n_resp < 2 * NREQ; cyc++) begin
            #1;
            if (req_ready != '0) begin
                chk("rr_grant", 64'(req_ready), 64'(onehot(exp_idx)));
                if (n_acc > 0) chk("rr_spacing", 64'(cyc - last_acc), 64'(LAT + 2));
                g = 0;
                for (int i = NREQ - 1; i >= 0; i--) if (req_ready[i]) g = i;
                own_q.push_back(g);
                prod_q.push_back(ref_prod(req_a[32*g +: 32], req_b[32*g +: 32]));
                due_q.push_back(cyc + 1 + LAT);
                last_acc    = cyc;
                n_acc++;
                exp_idx     = (g + 1) % NREQ;
                acc_pending = 1'b1;
            end
            if (resp_valid != '0) begin
                if (own_q.size() == 0) begin
                    chk("rr_spurious_resp", 64'(resp_valid), 64'd0);
                end else begin
                    o   = own_q.pop_front();
                    pp  = prod_q.pop_front();
                    due = due_q.pop_front();
                    chk("rr_resp_owner", 64'(resp_valid), 64'(onehot(o)));
                    chk("rr_resp_data", resp_data, pp);
                    chk("rr_resp_time", 64'(cyc), 64'(due));
                    n_resp++;
                end
            end
            @(posedge clk);
            #1;
            if (acc_pending) begin
                req_a[32*g +: 32] = $urandom;
                req_b[32*g +: 32] = $urandom;
                acc_pending = 1'b0;
            end
        end
        chk("rr_resp_count", 64'(n_resp), 64'(2 * NREQ));
        req_valid = '0;

        // Backpressure on requester 1 while others wait.
        do_reset();
        req_a[63:32] = $urandom;
        req_b[63:32] = $urandom;
        req_valid    = 4'b0010;
        #1;
        chk("bp_grant", 64'(req_ready), 64'h2);
        pa = ref_mag(req_a[63:32]);
        pb = ref_mag(req_b[63:32]);
        pp = ref_prod(req_a[63:32], req_b[63:32]);
        tick();
        req_a[31:0]   = $urandom;
        req_b[31:0]   = $urandom;
        req_a[127:96] = $urandom;
        req_b[127:96] = $urandom;
        req_valid     = 4'b1001;
        repeat (LAT) tick();
        resp_ready = 4'b1101;
        for (int k = 0; k < 10; k++) begin
            chk("bp_resp_valid", 64'(resp_valid), 64'h2);
            chk("bp_resp_data", resp_data, pp);
            chk("bp_mul_a", 64'(mul_a), 64'(pa));
            chk("bp_mul_b", 64'(mul_b), 64'(pb));
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        resp_ready = 4'b0010;
        tick();
        resp_ready = '0;
        chk("bp_released", 64'(resp_valid), 64'd0);
        chk("bp_next_grant", 64'(req_ready), 64'h8);

        // Reset in WAIT discards the operation; ptr returns to 0.
        do_reset();
        resp_ready    = '1;
        req_a[95:64]  = $urandom;
        req_b[95:64]  = $urandom;
        req_valid     = 4'b0100;
        #1;
        chk("rst_grant", 64'(req_ready), 64'h4);
        tick();
        a1 = $urandom;
        b1 = $urandom;
        req_a[63:32]  = a1;
        req_b[63:32]  = b1;
        req_a[127:96] = $urandom;
        req_b[127:96] = $urandom;
        req_valid     = 4'b1010;
        rst_n         = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_mul_a", 64'(mul_a), 64'd0);
        chk("rst_mul_b", 64'(mul_b), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_ptr_grant", 64'(req_ready), 64'h2);
        seen_bad = 1'b0;
        tick();
        req_valid = '0;
        chk("rst_next_mul_a", 64'(mul_a), 64'(ref_mag(a1)));
        for (int k = 0; k < LAT; k++) begin
            if (resp_valid[2]) seen_bad = 1'b1;
            tick();
        end
        chk("rst_next_valid", 64'(resp_valid), 64'h2);
        chk("rst_next_data", resp_data, ref_prod(a1, b1));
        tick();
        if (resp_valid[2]) seen_bad = 1'b1;
        chk("rst_no_stale_resp", 64'(seen_bad), 64'd0);

        // Requester 3 withdraws before its grant; requester 1 is served instead.
        do_reset();
        req_a[95:64] = $urandom;
        req_b[95:64] = $urandom;
        req_valid    = 4'b0100;
        #1;
        chk("drop_grant2", 64'(req_ready), 64'h4);
        tick();
        a3 = 32'h3C3C_3C3C;
        b3 = 32'h0000_0333;
        a1 = $urandom_range(1, 1000);
        b1 = $urandom_range(1, 1000);
        req_a[127:96] = a3;
        req_b[127:96] = b3;
        req_a[63:32]  = a1;
        req_b[63:32]  = b1;
        req_valid     = 4'b1010;
        seen_bad      = 1'b0;
        repeat (LAT) tick();
        req_valid = 4'b0010;
        #1;
        chk("drop_ready_in_resp", 64'(req_ready), 64'd0);
        resp_ready = 4'b0100;
        tick();
        resp_ready = '0;
        chk("drop_grant1", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        chk("drop_mul_a", 64'(mul_a), 64'(ref_mag(a1)));
        chk("drop_mul_b", 64'(mul_b), 64'(ref_mag(b1)));
        for (int k = 0; k < LAT; k++) begin
            if (mul_a == ref_mag(a3) || mul_b == ref_mag(b3)) seen_bad = 1'b1;
            tick();
        end
        chk("drop_resp_valid", 64'(resp_valid), 64'h2);
        chk("drop_resp_data", resp_data, ref_prod(a1, b1));
        resp_ready = 4'b0010;
        tick();
        resp_ready = '0;
        chk("drop_never_a3", 64'(seen_bad), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/wallace_mul_arbiter.md
# wallace_mul_arbiter

Round-robin arbiter and sequencer that shares one combinational 32x32 Wallace-tree multiplier (64-bit product) among NREQ requesters. It accepts one operand pair at a time over a valid/ready handshake, registers the operands onto the multiplier inputs, and waits a fixed multicycle settle time. It then captures the 64-bit product and returns it to the granted requester over a response handshake. It sits between client blocks and the multiplier instance; the multiplier itself stays purely combinational.

## Interface
- NREQ, 4: number of requesters, 2..8.
- LAT, 2: settle cycles allowed for the multiplier path, 1..15.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  32*NREQ  operand A; slice i is [32*i+31:32*i].
- req_b  in  32*NREQ  operand B, same packing.
- resp_valid  out  NREQ  per-requester result valid; at most one bit high.
- resp_ready  in  NREQ  per-requester result accept.
- resp_data  out  64  product, shared by all requesters; meaningful only where resp_valid is high.
- mul_a  out  32  registered operand to the multiplier.
- mul_b  out  32  registered operand to the multiplier.
- mul_out  in  64  product from the multiplier.

## Operation
- State machine:
  - IDLE: grant = first i with req_valid[i], searching from ptr upward and wrapping at NREQ-1. req_ready = grant one-hot, qualified by rst_n. On handshake: owner <- i, mul_a/mul_b <- operands, cnt <- LAT, go to WAIT.
  - WAIT: cnt decrements each cycle. When cnt==1: resp_data <- mul_out (after optional sign fix-up), go to RESP.
  - RESP: resp_valid[owner]=1. When resp_ready[owner]=1: go to IDLE, ptr <- (owner+1) mod NREQ.
- req_ready is 0 outside IDLE and whenever req_valid is 0.
- A requester holds req_valid, req_a and req_b stable until its req_ready. Dropping valid before the grant is legal in IDLE; the arbiter re-evaluates each cycle.
- resp_ready from non-owners is ignored. resp_data and resp_valid hold until accepted, indefinitely if needed.
- mul_a and mul_b stay stable from the accept edge through the end of RESP. resp_data stays stable during RESP.
- ptr gives the lowest priority to the most recently served requester. Sustained requests from all NREQ requesters are served in strict rotation 0,1,...,NREQ-1,0.
- Reset values: state IDLE, ptr 0, owner 0, cnt 0, req_ready 0, resp_valid 0, resp_data 0, mul_a 0, mul_b 0.
- Reset asserted mid-operation discards the in-flight operation. No response is ever issued for it.

## Timing
- The accept edge is edge 0. The product is captured at edge LAT, and resp_valid is high in the cycle after edge LAT.
- The path from mul_a/mul_b to mul_out is a LAT-cycle multicycle path.
- The earliest next accept is the first edge after the response handshake edge, because IDLE lasts at least one cycle.
- Minimum period per operation is LAT+2 cycles: LAT in WAIT, 1 in RESP, 1 in IDLE.
- There is no combinational path from req_* to resp_* or to mul_*. req_ready depends combinationally on req_valid, state and ptr.

## Configuration
- MUL_ARB_SIGNED_EN defined: operands are two's complement.
  - mul_a and mul_b carry the magnitudes |a| and |b|; 0x80000000 maps to 0x80000000.
  - The captured product is negated (64-bit two's complement) when a[31]^b[31]=1, unless the product is zero.
  - The sign bit is registered at accept.
- MUL_ARB_SIGNED_EN undefined: operands are unsigned and pass unchanged; resp_data = mul_out. No sign logic is present.

## Test plan
- Single request, unsigned build, NREQ=4, LAT=2: req 2 sends a=0xFFFFFFFD, b=5 -> resp_valid[2] high in the cycle after edge 2, resp_data=0x00000004FFFFFFF1, other resp_valid bits 0.
- Signed build, same stimulus -> resp_data=0xFFFFFFFFFFFFFFF1. Then a=0x80000000, b=0x80000000 -> 0x4000000000000000. Then a=0, b=0xFFFFFFFF -> 0.
- All four requesters held valid continuously from reset (ptr=0), each with resp_ready=1 -> grant order 0,1,2,3,0; one accept every LAT+2=4 cycles; each resp_data = a_i*b_i.
- Backpressure: resp_ready[1]=0 for 10 cycles during RESP -> resp_valid[1], resp_data, mul_a and mul_b stable; req_ready all 0; no second accept until the handshake completes.
- rst_n pulsed low during WAIT -> all outputs 0 immediately; ptr=0; no resp_valid for the discarded operation; the next request is served normally.
- Requester 3 drops req_valid in IDLE before its grant while requester 1 stays valid -> requester 1 accepted; requester 3's operands never appear on mul_a or mul_b.
